ifetch_ctrl: RTL and testbench



---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 64 ++++++
 rtl/ifetch_ctrl.sv | 100 ++++++++++
 tb/tb_ifetch_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths, reset PC and the prefetch entry layout for the sisc fetch unit.
package ifetch_pkg;

    localparam int IF_ADDR_W = 16;
    localparam int IF_DATA_W = 32;
    localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Saturating increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous prefetch FIFO holding {pc, instr} entries; flush empties it in one cycle.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  entry_t        data_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: PC, IM addressing, prefetch buffer and decode handshake.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W,
    parameter int DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [CW-1:0]     buf_count
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pop, push, full;
    fetch_entry_t      wr_entry, head;
    logic [CW-1:0]     count;

    assign full        = (count == CW'(DEPTH));
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    // A full buffer still accepts a new entry when the head leaves in the same cycle.
    assign push        = fetch_en & ~redirect & (~full | pop);

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = pc_q;
        wr_entry.instr = im_data;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect)  pc_d = redirect_pc;
        else if (push) pc_d = pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    ifetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_i  (wr_entry),
        .head_o  (head),
        .count_o (count)
    );

    assign im_addr    = pc_q;
    assign buf_count  = count;
    assign instr_data = instr_valid ? head.instr : '0;
    assign instr_pc   = instr_valid ? head.pc    : '0;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push)                              fetch_cnt_q <= sat_inc32(fetch_cnt_q);
            if (fetch_en && !push && !redirect)    stall_cnt_q <= sat_inc32(stall_cnt_q);
            if (redirect)                          flush_cnt_q <= sat_inc16(flush_cnt_q);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_ifetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [15:0] instr_pc;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic [1:0]  buf_count;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
    logic [31:0] m_fetch, m_stall;
    logic [15:0] m_flush;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of {pc, instr}, plus the PC the fetcher will present next.
    logic [47:0] m_q[$];
    logic [15:0] m_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [15:0] a);
        return {16'hAA00, a};
    endfunction

    assign im_data = imem_f(im_addr);

    ifetch_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .buf_count   (buf_count)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [47:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 48'h0;
        chk("im_addr", 64'(im_addr), 64'(m_pc));
        chk("instr_valid", 64'(instr_valid), 64'(m_q.size() > 0));
        chk("instr_pc", 64'(instr_pc), 64'(h[47:32]));
        chk("instr_data", 64'(instr_data), 64'(h[31:0]));
        chk("buf_count", 64'(buf_count), 64'(m_q.size()));
`ifdef IFETCH_PERF_EN
        chk("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch));
        chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
        chk("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
`endif
    endtask

    task automatic model_step();
        bit pop, push;
        if (rst) begin
            m_q.delete();
            m_pc = 16'h0000;
`ifdef IFETCH_PERF_EN
            m_fetch = 0; m_stall = 0; m_flush = 0;
`endif
        end else if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc;
`ifdef IFETCH_PERF_EN
            if (m_flush != 16'hFFFF) m_flush++;
`endif
        end else begin
            pop  = (m_q.size() > 0) && instr_ready;
            push = fetch_en && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, imem_f(m_pc)});
                m_pc = m_pc + 16'd1;
            end
`ifdef IFETCH_PERF_EN
            if (push && m_fetch != 32'hFFFFFFFF) m_fetch++;
            if (fetch_en && !push && m_stall != 32'hFFFFFFFF) m_stall++;
`endif
        end
    endtask

    // Check the state visible at this falling edge, then drive the next cycle's inputs.
    task automatic tick(input logic r, input logic f, input logic rd,
                        input logic rr, input logic [15:0] rp);
        @(negedge clk);
        compare_all();
        rst = r; fetch_en = f; instr_ready = rd; redirect = rr; redirect_pc = rp;
        model_step();
    endtask

    initial begin
        logic [15:0] frz;
        logic [15:0] wrap_seq [4];
        wrap_seq[0] = 16'hFFFE; wrap_seq[1] = 16'hFFFF;
        wrap_seq[2] = 16'h0000; wrap_seq[3] = 16'h0001;

        m_pc = 16'h0000;
`ifdef IFETCH_PERF_EN
        m_fetch = 0; m_stall = 0; m_flush = 0;
`endif

        // Reset, then stream from address 0 with decode always ready.
        tick(1, 0, 0, 0, 16'h0);
        tick(1, 1, 1, 0, 16'h0);
        chk("rst_im_addr", 64'(im_addr), 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'h0);
        chk("rst_count", 64'(buf_count), 64'h0);
        tick(0, 1, 1, 0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 1, 0, 16'h0);
            chk("stream_valid", 64'(instr_valid), 64'h1);
            chk("stream_pc", 64'(instr_pc), 64'(i));
            chk("stream_data", 64'(instr_data), 64'(32'hAA000000 + i));
        end

        // Back-pressure from reset: buffer fills, PC and head hold, release drains in order.
        tick(1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 16'h0);
        chk("stall_count", 64'(buf_count), 64'h2);
        chk("stall_im_addr", 64'(im_addr), 64'h2);
        chk("stall_data", 64'(instr_data), 64'hAA000000);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 0, 16'h0);
            chk("release_pc", 64'(instr_pc), 64'(i));
        end

        // Redirect while full with a pending pop.
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 16'h0);
        chk("pre_redir_full", 64'(buf_count), 64'h2);
        tick(0, 1, 1, 1, 16'h0040);
        tick(0, 1, 1, 0, 16'h0);
        chk("redir_count", 64'(buf_count), 64'h0);
        chk("redir_im_addr", 64'(im_addr), 64'h0040);
        chk("redir_valid", 64'(instr_valid), 64'h0);
        tick(0, 1, 1, 0, 16'h0);
        chk("redir_head_valid", 64'(instr_valid), 64'h1);
        chk("redir_head_pc", 64'(instr_pc), 64'h0040);

        // PC wrap through the top of the address space.
        tick(0, 1, 1, 1, 16'hFFFE);
        tick(0, 1, 1, 0, 16'h0);
        chk("wrap_im_addr", 64'(im_addr), 64'hFFFE);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 1, 0, 16'h0);
            chk("wrap_pc", 64'(instr_pc), 64'(wrap_seq[i]));
        end

        // fetch_en low: PC frozen, buffer drains, fetching resumes at the frozen PC.
        frz = m_pc;
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 16'h0);
        chk("freeze_count", 64'(buf_count), 64'h0);
        chk("freeze_im_addr", 64'(im_addr), 64'(frz));
        tick(0, 1, 1, 0, 16'h0);
        tick(0, 1, 1, 0, 16'h0);
        chk("resume_pc", 64'(instr_pc), 64'(frz));

        // Reset wins over a simultaneous redirect with a full buffer.
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 16'h0);
        tick(1, 1, 0, 1, 16'h1234);
        tick(0, 0, 0, 0, 16'h0);
        chk("rst2_im_addr", 64'(im_addr), 64'h0);
        chk("rst2_valid", 64'(instr_valid), 64'h0);
        chk("rst2_count", 64'(buf_count), 64'h0);
        chk("rst2_data", 64'(instr_data), 64'h0);
        chk("rst2_pc", 64'(instr_pc), 64'h0);
`ifdef IFETCH_PERF_EN
        chk("rst2_perf_fetch", 64'(perf_fetch_cnt), 64'h0);
        chk("rst2_perf_stall", 64'(perf_stall_cnt), 64'h0);
        chk("rst2_perf_flush", 64'(perf_flush_cnt), 64'h0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r, f, rd, rr;
            logic [15:0] rp;
            r  = ($urandom_range(63) == 0);
            rr = ($urandom_range(15) == 0);
            f  = ($urandom_range(3) != 0);
            rd = ($urandom_range(1) == 1);
            rp = ($urandom_range(3) == 0) ? 16'($urandom_range(16'hFFFF, 16'hFFFC))
                                          : 16'($urandom);
            tick(r, f, rd, rr, rp);
        end
        tick(0, 0, 0, 0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
